// File: rtl/spasdff_pipe.sv
// Elastic pipeline register bank: DEPTH valid-tagged stages with a collapsing
// ready chain, synchronous flush, occupancy count and a registered complement output.
module spasdff_pipe #(
   parameter int unsigned          WIDTH     = 10,
   parameter int unsigned          DEPTH     = 2,
   parameter logic [WIDTH-1:0]     RESET_VAL = '0,
   localparam int unsigned         CNT_W     = $clog2(DEPTH + 1)
) (
   input  logic                clk,
   input  logic                reset_l,
   input  logic [WIDTH-1:0]    in,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic                flush,
   output logic [WIDTH-1:0]    out,
   output logic [WIDTH-1:0]    outn,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [CNT_W-1:0]    count
);

   logic [DEPTH-1:0] v_q, v_d;
   logic [WIDTH-1:0] data_q [DEPTH];
   logic [WIDTH-1:0] data_d [DEPTH];
   logic [WIDTH-1:0] outn_q, outn_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic [DEPTH-1:0] rdy;
   logic             rdy_acc;
   logic [DEPTH-1:0] src_v;
   logic [WIDTH-1:0] src_d [DEPTH];
   logic             in_xfer;
   logic             out_xfer;

   // A stage can advance if it is empty or everything downstream of it can advance.
   always_comb begin
      rdy_acc = out_ready;
      rdy     = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         rdy_acc = ~v_q[i] | rdy_acc;
         rdy[i]  = rdy_acc;
      end
   end

   always_comb begin
      src_v[0] = in_valid;
      src_d[0] = in;
      for (int i = 1; i < DEPTH; i++) begin
         src_v[i] = v_q[i-1];
         src_d[i] = data_q[i-1];
      end
   end

   assign in_ready = rdy[0] & ~flush;
   assign in_xfer  = in_valid & in_ready;
   assign out_xfer = v_q[DEPTH-1] & out_ready;

   // Data only moves with a valid beat behind it, so empty slots keep their old contents.
   always_comb begin
      v_d    = v_q;
      data_d = data_q;
      for (int i = 0; i < DEPTH; i++) begin
         if (rdy[i]) begin
            v_d[i] = src_v[i];
            if (src_v[i] && !flush) begin
               data_d[i] = src_d[i];
            end
         end
      end
      if (flush) begin
         v_d = '0;
      end
      outn_d = ~data_d[DEPTH-1];
   end

   always_comb begin
      if (flush) begin
         count_d = '0;
      end else begin
         count_d = count_q + CNT_W'(in_xfer) - CNT_W'(out_xfer);
      end
   end

   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         v_q     <= '0;
         outn_q  <= ~RESET_VAL;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            data_q[i] <= RESET_VAL;
         end
      end else begin
         v_q     <= v_d;
         outn_q  <= outn_d;
         count_q <= count_d;
         for (int i = 0; i < DEPTH; i++) begin
            data_q[i] <= data_d[i];
         end
      end
   end

   assign out       = data_q[DEPTH-1];
   assign outn      = outn_q;
   assign out_valid = v_q[DEPTH-1];
   assign count     = count_q;

endmodule

// File: tb/tb_spasdff_pipe.sv
// Directed bench for spasdff_pipe: a DEPTH=2 instance with a non-zero reset value
// and a DEPTH=3 instance for bubble collapse.
module tb_spasdff_pipe;

   logic clk;
   logic reset_l;

   logic [9:0] a_in, a_out, a_outn;
   logic       a_vld, a_rdy, a_flush, a_ovld, a_ordy;
   logic [1:0] a_cnt;

   logic [9:0] b_in, b_out, b_outn;
   logic       b_vld, b_rdy, b_flush, b_ovld, b_ordy;
   logic [1:0] b_cnt;

   int vecs;
   int errs;

   spasdff_pipe #(.WIDTH(10), .DEPTH(2), .RESET_VAL(10'h155)) u_a (
      .clk(clk), .reset_l(reset_l), .in(a_in), .in_valid(a_vld), .in_ready(a_rdy),
      .flush(a_flush), .out(a_out), .outn(a_outn), .out_valid(a_ovld),
      .out_ready(a_ordy), .count(a_cnt)
   );

   spasdff_pipe #(.WIDTH(10), .DEPTH(3), .RESET_VAL(10'h000)) u_b (
      .clk(clk), .reset_l(reset_l), .in(b_in), .in_valid(b_vld), .in_ready(b_rdy),
      .flush(b_flush), .out(b_out), .outn(b_outn), .out_valid(b_ovld),
      .out_ready(b_ordy), .count(b_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_l = 1'b0;
      a_in = '0; a_vld = 0; a_flush = 0; a_ordy = 0;
      b_in = '0; b_vld = 0; b_flush = 0; b_ordy = 0;
      repeat (2) @(negedge clk);
      reset_l = 1'b1;
      #1;
      vecs++; if (a_out !== 10'h155) begin errs++; $display("FAIL reset_out got %h want %h", a_out, 10'h155); end
      vecs++; if (a_outn !== 10'h2AA) begin errs++; $display("FAIL reset_outn got %h want %h", a_outn, 10'h2AA); end
      vecs++; if (a_ovld !== 1'b0) begin errs++; $display("FAIL reset_out_valid got %b want 0", a_ovld); end
      vecs++; if (a_cnt !== 2'd0) begin errs++; $display("FAIL reset_count got %0d want 0", a_cnt); end
      vecs++; if (a_rdy !== 1'b1) begin errs++; $display("FAIL reset_in_ready got %b want 1", a_rdy); end
   endtask

   task automatic test_stream();
      logic       exp_v [6];
      logic [9:0] exp_d [6];
      logic [1:0] exp_c [6];
      exp_v = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      exp_d = '{10'h155, 10'd1, 10'd2, 10'd3, 10'd4, 10'd4};
      exp_c = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd1, 2'd0};
      tick();
      a_ordy = 1'b1;
      for (int k = 0; k < 6; k++) begin
         a_vld = (k < 4);
         a_in  = (k < 4) ? 10'(k + 1) : 10'h0;
         tick();
         vecs++; if (a_ovld !== exp_v[k]) begin errs++; $display("FAIL stream_valid[%0d] got %b want %b", k, a_ovld, exp_v[k]); end
         vecs++; if (a_out !== exp_d[k]) begin errs++; $display("FAIL stream_out[%0d] got %h want %h", k, a_out, exp_d[k]); end
         vecs++; if (a_outn !== ~exp_d[k]) begin errs++; $display("FAIL stream_outn[%0d] got %h want %h", k, a_outn, ~exp_d[k]); end
         vecs++; if (a_cnt !== exp_c[k]) begin errs++; $display("FAIL stream_count[%0d] got %0d want %0d", k, a_cnt, exp_c[k]); end
      end
   endtask

   task automatic test_backpressure();
      a_ordy = 1'b0;
      a_vld = 1'b1; a_in = 10'd5;
      #1;
      vecs++; if (a_rdy !== 1'b1) begin errs++; $display("FAIL bp_rdy_empty got %b want 1", a_rdy); end
      tick();
      a_in = 10'd6;
      tick();
      a_in = 10'd7;
      #1;
      vecs++; if (a_cnt !== 2'd2) begin errs++; $display("FAIL bp_count_full got %0d want 2", a_cnt); end
      vecs++; if (a_rdy !== 1'b0) begin errs++; $display("FAIL bp_rdy_full got %b want 0", a_rdy); end
      tick();
      vecs++; if (a_out !== 10'd5 || a_ovld !== 1'b1) begin errs++; $display("FAIL bp_hold got %h/%b want 005/1", a_out, a_ovld); end
      vecs++; if (a_cnt !== 2'd2) begin errs++; $display("FAIL bp_count_hold got %0d want 2", a_cnt); end
      a_ordy = 1'b1;
      #1;
      vecs++; if (a_rdy !== 1'b1) begin errs++; $display("FAIL bp_rdy_drain got %b want 1", a_rdy); end
      tick();
      a_vld = 1'b0;
      vecs++; if (a_out !== 10'd6 || a_ovld !== 1'b1) begin errs++; $display("FAIL bp_drain1 got %h/%b want 006/1", a_out, a_ovld); end
      vecs++; if (a_cnt !== 2'd2) begin errs++; $display("FAIL bp_count_same got %0d want 2", a_cnt); end
      tick();
      vecs++; if (a_out !== 10'd7 || a_ovld !== 1'b1) begin errs++; $display("FAIL bp_drain2 got %h/%b want 007/1", a_out, a_ovld); end
      vecs++; if (a_cnt !== 2'd1) begin errs++; $display("FAIL bp_count_drain2 got %0d want 1", a_cnt); end
      tick();
      vecs++; if (a_ovld !== 1'b0 || a_cnt !== 2'd0) begin errs++; $display("FAIL bp_empty got %b/%0d want 0/0", a_ovld, a_cnt); end
   endtask

   task automatic test_bubble();
      b_ordy = 1'b0;
      b_vld = 1'b1; b_in = 10'h009;
      tick();
      b_vld = 1'b0;
      repeat (2) tick();
      vecs++; if (b_ovld !== 1'b1 || b_out !== 10'h009) begin errs++; $display("FAIL bub_head got %h/%b want 009/1", b_out, b_ovld); end
      vecs++; if (b_cnt !== 2'd1) begin errs++; $display("FAIL bub_count1 got %0d want 1", b_cnt); end
      b_vld = 1'b1; b_in = 10'h00A;
      #1;
      vecs++; if (b_rdy !== 1'b1) begin errs++; $display("FAIL bub_rdy1 got %b want 1", b_rdy); end
      tick();
      b_in = 10'h00B;
      #1;
      vecs++; if (b_rdy !== 1'b1) begin errs++; $display("FAIL bub_rdy2 got %b want 1", b_rdy); end
      vecs++; if (b_cnt !== 2'd2) begin errs++; $display("FAIL bub_count2 got %0d want 2", b_cnt); end
      tick();
      b_in = 10'h00C;
      #1;
      vecs++; if (b_cnt !== 2'd3) begin errs++; $display("FAIL bub_count3 got %0d want 3", b_cnt); end
      vecs++; if (b_rdy !== 1'b0) begin errs++; $display("FAIL bub_rdy_full got %b want 0", b_rdy); end
      b_vld = 1'b0; b_ordy = 1'b1;
      tick();
      vecs++; if (b_out !== 10'h00A || b_ovld !== 1'b1) begin errs++; $display("FAIL bub_drain1 got %h/%b want 00a/1", b_out, b_ovld); end
      tick();
      vecs++; if (b_out !== 10'h00B || b_ovld !== 1'b1) begin errs++; $display("FAIL bub_drain2 got %h/%b want 00b/1", b_out, b_ovld); end
      tick();
      vecs++; if (b_ovld !== 1'b0 || b_cnt !== 2'd0) begin errs++; $display("FAIL bub_empty got %b/%0d want 0/0", b_ovld, b_cnt); end
   endtask

   task automatic test_flush();
      a_ordy = 1'b0;
      a_vld = 1'b1; a_in = 10'h3C1;
      tick();
      a_in = 10'h3C2;
      tick();
      vecs++; if (a_cnt !== 2'd2 || a_out !== 10'h3C1) begin errs++; $display("FAIL fl_full got %0d/%h want 2/3c1", a_cnt, a_out); end
      a_flush = 1'b1; a_in = 10'h3FF;
      #1;
      vecs++; if (a_rdy !== 1'b0) begin errs++; $display("FAIL fl_rdy got %b want 0", a_rdy); end
      tick();
      a_flush = 1'b0; a_vld = 1'b0;
      vecs++; if (a_ovld !== 1'b0) begin errs++; $display("FAIL fl_valid got %b want 0", a_ovld); end
      vecs++; if (a_cnt !== 2'd0) begin errs++; $display("FAIL fl_count got %0d want 0", a_cnt); end
      vecs++; if (a_out !== 10'h3C1) begin errs++; $display("FAIL fl_out_hold got %h want 3c1", a_out); end
      vecs++; if (a_outn !== 10'h03E) begin errs++; $display("FAIL fl_outn_hold got %h want 03e", a_outn); end
      tick();
      vecs++; if (a_ovld !== 1'b0 || a_cnt !== 2'd0) begin errs++; $display("FAIL fl_no_accept got %b/%0d want 0/0", a_ovld, a_cnt); end
   endtask

   task automatic test_async_reset();
      a_ordy = 1'b0;
      a_vld = 1'b1; a_in = 10'h011;
      tick();
      a_in = 10'h022;
      tick();
      a_vld = 1'b0;
      vecs++; if (a_cnt !== 2'd2) begin errs++; $display("FAIL ar_pre_count got %0d want 2", a_cnt); end
      @(negedge clk);
      #2;
      reset_l = 1'b0;
      #1;
      vecs++; if (a_ovld !== 1'b0) begin errs++; $display("FAIL ar_valid got %b want 0", a_ovld); end
      vecs++; if (a_cnt !== 2'd0) begin errs++; $display("FAIL ar_count got %0d want 0", a_cnt); end
      vecs++; if (a_out !== 10'h155) begin errs++; $display("FAIL ar_out got %h want 155", a_out); end
      vecs++; if (a_outn !== 10'h2AA) begin errs++; $display("FAIL ar_outn got %h want 2aa", a_outn); end
      @(negedge clk);
      reset_l = 1'b1;
      tick();
      vecs++; if (a_ovld !== 1'b0 || a_cnt !== 2'd0) begin errs++; $display("FAIL ar_after got %b/%0d want 0/0", a_ovld, a_cnt); end
   endtask

   initial begin
      vecs = 0;
      errs = 0;
      test_reset();
      test_stream();
      test_backpressure();
      test_bubble();
      test_flush();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
